// File: rtl/enemy_fleet_if.sv
// enemy_fleet_if: game-logic/VGA side bus of the enemy fleet block
//   master : tick/enable strobes, road and player geometry, VGA scan position in; status and pixel out
//   slave  : the fleet itself
//   logic_tick 1, enable 1, offset_x/player_x/player_y/hcount/vcount 10 -> fleet
//   active N, hit 1, hit_idx 3, passed 1, data 3 <- fleet
interface enemy_fleet_if #(
    parameter int N_ENEMIES = 4
);
    logic                 logic_tick;
    logic                 enable;
    logic [9:0]           offset_x;
    logic [9:0]           player_x;
    logic [9:0]           player_y;
    logic [9:0]           hcount;
    logic [9:0]           vcount;
    logic [N_ENEMIES-1:0] active;
    logic                 hit;
    logic [2:0]           hit_idx;
    logic                 passed;
    logic [2:0]           data;
    modport master (
        output logic_tick, enable, offset_x, player_x, player_y, hcount, vcount,
        input  active, hit, hit_idx, passed, data
    );
    modport slave (
        input  logic_tick, enable, offset_x, player_x, player_y, hcount, vcount,
        output active, hit, hit_idx, passed, data
    );
endinterface

// File: rtl/enemy_fleet.sv
// enemy_fleet: N_ENEMIES enemy cars - LFSR spawn, downward scroll, player hit detection, VGA render
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   bus    : enemy_fleet_if.slave (tick/enable, geometry and scan position in; active/hit/hit_idx/passed/data out)
//   Optional ENEMY_FLEET_SPEEDUP_EN: every 16 passed cars raise the scroll speed by 1, up to 2*SPEED.
module enemy_fleet #(
    parameter int       N_ENEMIES = 4,
    parameter int       SPRITE_W  = 32,
    parameter int       SPRITE_H  = 48,
    parameter int       LANE_W    = 64,
    parameter int       SCREEN_H  = 480,
    parameter int       SPEED     = 2,
    parameter int       SPAWN_GAP = 30,
    parameter int       HIT_TICKS = 16,
    parameter bit [7:0] LFSR_SEED = 8'hA5
) (
    input logic         clk,
    input logic         reset,
    enemy_fleet_if.slave bus
);
    localparam int CW = $clog2(HIT_TICKS + 1);
    localparam int TW = $clog2(SPAWN_GAP + 1);
    localparam logic [10:0]   SW  = 11'(SPRITE_W);
    localparam logic [10:0]   SH  = 11'(SPRITE_H);
    localparam logic [10:0]   LIM = 11'(SCREEN_H);
    localparam logic [10:0]   SP  = 11'(SPEED);
    localparam logic [TW-1:0] GAP = TW'(SPAWN_GAP);
    localparam logic [CW-1:0] HT  = CW'(HIT_TICKS);

    typedef enum logic [1:0] {IDLE, ACTIVE, HIT} slot_t;

    slot_t          st  [N_ENEMIES];
    logic [9:0]     xs  [N_ENEMIES];
    logic [9:0]     ys  [N_ENEMIES];
    logic [1:0]     ln  [N_ENEMIES];
    logic [CW-1:0]  cnt [N_ENEMIES];
    logic [10:0]    sum [N_ENEMIES];
    logic [TW-1:0]  tmr, tmr_dec;
    logic [7:0]     lfsr;
    logic [10:0]    spd;
    logic [1:0]     lane;
    logic [9:0]     new_x;
    logic           tick, free_ok, blocked, do_spawn, any_hit, any_pass;
    logic [2:0]     free_idx, hit_low, pix;
    logic [N_ENEMIES-1:0] ovl, exits, act_v;
    logic           hit_r, pass_r;
    logic [2:0]     idx_r, data_r;

    assign tick  = bus.logic_tick & bus.enable;
    assign lane  = lfsr[1:0];
    assign new_x = bus.offset_x + 10'(int'(lane) * LANE_W);

    // Descending loops let the lowest index win for free-slot, first-hit and pixel priority.
    always_comb begin
        tmr_dec  = (tmr == '0) ? '0 : tmr - 1'b1;
        free_ok  = 1'b0;
        free_idx = '0;
        blocked  = 1'b0;
        hit_low  = '0;
        pix      = '0;
        ovl      = '0;
        exits    = '0;
        act_v    = '0;
        for (int i = N_ENEMIES - 1; i >= 0; i--) begin
            sum[i]   = {1'b0, ys[i]} + spd;
            act_v[i] = st[i] != IDLE;
            ovl[i]   = st[i] == ACTIVE
                       && {1'b0, xs[i]} < {1'b0, bus.player_x} + SW
                       && {1'b0, bus.player_x} < {1'b0, xs[i]} + SW
                       && {1'b0, ys[i]} < {1'b0, bus.player_y} + SH
                       && {1'b0, bus.player_y} < {1'b0, ys[i]} + SH;
            // a hit on the same tick as the bottom exit suppresses the pass
            exits[i] = st[i] == ACTIVE && !ovl[i] && sum[i] >= LIM;
            if (st[i] == IDLE) begin
                free_ok  = 1'b1;
                free_idx = 3'(i);
            end
            // keep a fresh spawn from landing on top of a car still entering the same lane
            if (st[i] != IDLE && ln[i] == lane && {1'b0, ys[i]} < SH)
                blocked = 1'b1;
            if (ovl[i])
                hit_low = 3'(i);
            if (st[i] != IDLE && bus.hcount >= xs[i] && {1'b0, bus.hcount} < {1'b0, xs[i]} + SW
                && bus.vcount >= ys[i] && {1'b0, bus.vcount} < {1'b0, ys[i]} + SH)
                pix = (st[i] == ACTIVE) ? 3'b100 : (cnt[i][1] ? 3'b110 : 3'b000);
        end
        any_hit  = |ovl;
        any_pass = |exits;
        do_spawn = tmr_dec == '0 && free_ok && !blocked;
    end

`ifdef ENEMY_FLEET_SPEEDUP_EN
    localparam logic [10:0] SPMAX = 11'(2 * SPEED);
    logic [3:0] pass_cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pass_cnt <= '0;
            spd      <= SP;
        end else if (tick && any_pass) begin
            pass_cnt <= pass_cnt + 1'b1;
            if (pass_cnt == 4'hF && spd < SPMAX)
                spd <= spd + 1'b1;
        end
    end
`else
    assign spd = SP;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_ENEMIES; i++) begin
                st[i]  <= IDLE;
                xs[i]  <= '0;
                ys[i]  <= '0;
                ln[i]  <= '0;
                cnt[i] <= '0;
            end
            tmr    <= GAP;
            lfsr   <= LFSR_SEED;
            hit_r  <= 1'b0;
            pass_r <= 1'b0;
            idx_r  <= '0;
            data_r <= '0;
        end else begin
            data_r <= pix;
            hit_r  <= tick && any_hit;
            pass_r <= tick && any_pass;
            if (tick && any_hit)
                idx_r <= hit_low;
            if (tick) begin
                lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                tmr  <= do_spawn ? GAP : tmr_dec;
                for (int i = 0; i < N_ENEMIES; i++) begin
                    case (st[i])
                        IDLE: if (do_spawn && free_idx == 3'(i)) begin
                            st[i] <= ACTIVE;
                            xs[i] <= new_x;
                            ys[i] <= '0;
                            ln[i] <= lane;
                        end
                        ACTIVE: if (ovl[i]) begin
                            st[i]  <= HIT;
                            cnt[i] <= HT;
                        end else if (exits[i]) begin
                            st[i] <= IDLE;
                        end else begin
                            ys[i] <= sum[i][9:0];
                        end
                        HIT: begin
                            cnt[i] <= cnt[i] - 1'b1;
                            if (cnt[i] == CW'(1))
                                st[i] <= IDLE;
                        end
                        default: st[i] <= IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.active  = act_v;
    assign bus.hit     = hit_r;
    assign bus.hit_idx = idx_r;
    assign bus.passed  = pass_r;
    assign bus.data    = data_r;
endmodule

// File: tb/tb_enemy_fleet.sv
// tb_enemy_fleet: directed and randomized checks of enemy_fleet against a behavioural fleet model
module tb_enemy_fleet;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    enemy_fleet_if #(.N_ENEMIES(N)) bus();
    enemy_fleet #(.N_ENEMIES(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: st 0=idle 1=driving 2=crashed
    int m_st [N];
    int m_x  [N];
    int m_y  [N];
    int m_ln [N];
    int m_cnt[N];
    int m_tmr;
    int m_lfsr;

    typedef struct {
        int dx;
        int dy;
        int exp;
    } pix_vec_t;
    pix_vec_t tbl [8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int lfsr_next(input int v);
        return ((v << 1) & 255) | (((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1);
    endfunction

    function automatic int act_mask();
        int m = 0;
        for (int i = 0; i < N; i++) if (m_st[i] != 0) m += (1 << i);
        return m;
    endfunction

    function automatic int render(input int hc, input int vc);
        for (int i = 0; i < N; i++)
            if (m_st[i] != 0 && hc >= m_x[i] && hc < m_x[i] + 32 && vc >= m_y[i] && vc < m_y[i] + 48)
                return (m_st[i] == 1) ? 4 : (((m_cnt[i] >> 1) & 1) ? 6 : 0);
        return 0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_x[i] = 0; m_y[i] = 0; m_ln[i] = 0; m_cnt[i] = 0;
        end
        m_tmr  = 30;
        m_lfsr = 'hA5;
    endtask

    task automatic m_tick(output bit h, output int hi, output bit p);
        int lane, t, fr, px, py;
        bit blk;
        lane = m_lfsr & 3;
        t    = (m_tmr > 0) ? m_tmr - 1 : 0;
        px   = bus.player_x;
        py   = bus.player_y;
        fr   = -1;
        blk  = 0;
        h = 0; hi = 0; p = 0;
        for (int i = 0; i < N; i++) begin
            if (m_st[i] == 0 && fr < 0) fr = i;
            if (m_st[i] != 0 && m_ln[i] == lane && m_y[i] < 48) blk = 1;
        end
        for (int i = 0; i < N; i++) begin
            if (m_st[i] == 1) begin
                if (m_x[i] < px + 32 && px < m_x[i] + 32 && m_y[i] < py + 48 && py < m_y[i] + 48) begin
                    m_st[i] = 2; m_cnt[i] = 16;
                    if (!h) hi = i;
                    h = 1;
                end else if (m_y[i] + 2 >= 480) begin
                    m_st[i] = 0; p = 1;
                end else m_y[i] += 2;
            end else if (m_st[i] == 2) begin
                m_cnt[i] -= 1;
                if (m_cnt[i] == 0) m_st[i] = 0;
            end
        end
        if (t == 0 && fr >= 0 && !blk) begin
            m_st[fr] = 1; m_x[fr] = (bus.offset_x + lane * 64) & 1023; m_y[fr] = 0; m_ln[fr] = lane;
            m_tmr = 30;
        end else m_tmr = t;
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    task automatic step(input bit tk, input bit en);
        bit h, p;
        int hi, ed;
        bus.logic_tick = tk;
        bus.enable     = en;
        ed = render(bus.hcount, bus.vcount);
        h = 0; p = 0; hi = 0;
        if (tk && en) m_tick(h, hi, p);
        @(posedge clk);
        #1;
        bus.logic_tick = 1'b0;
        chk("active", int'(bus.active), act_mask());
        chk("hit", int'(bus.hit), int'(h));
        chk("passed", int'(bus.passed), int'(p));
        chk("data", int'(bus.data), ed);
        if (h) chk("hit_idx", int'(bus.hit_idx), hi);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.logic_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_active", int'(bus.active), 0);
        chk("rst_data", int'(bus.data), 0);
        chk("rst_hit", int'(bus.hit), 0);
        chk("rst_passed", int'(bus.passed), 0);
        chk("rst_hit_idx", int'(bus.hit_idx), 0);
        m_reset();
        reset = 1'b1;
    endtask

    initial begin
        int lf, cx, n, j;
        tbl[0] = '{0, 0, 4};
        tbl[1] = '{31, 0, 4};
        tbl[2] = '{32, 0, 0};
        tbl[3] = '{-1, 0, 0};
        tbl[4] = '{0, 47, 4};
        tbl[5] = '{0, 48, 0};
        tbl[6] = '{16, 24, 4};
        tbl[7] = '{31, 47, 4};
        bus.logic_tick = 1'b0;
        bus.enable     = 1'b0;
        bus.offset_x   = 10'd129;
        bus.player_x   = 10'd1000;
        bus.player_y   = 10'd0;
        bus.hcount     = 10'd0;
        bus.vcount     = 10'd0;

        do_reset();

        lf = 'hA5;
        repeat (29) lf = lfsr_next(lf);
        cx = 129 + 64 * (lf & 3);
        for (int k = 0; k < 29; k++) step(1, 1);
        chk("pre_spawn_active", int'(bus.active), 0);
        step(1, 1);
        chk("spawn_active", int'(bus.active), 1);
        for (int k = 0; k < 8; k++) begin
            bus.hcount = 10'(cx + tbl[k].dx);
            bus.vcount = 10'(tbl[k].dy);
            step(0, 1);
            chk($sformatf("spawn_pix%0d", k), int'(bus.data), tbl[k].exp);
        end

        n = 0;
        for (int k = 0; k < 400; k++) begin
            step(1, 1);
            n++;
            if (bus.passed) break;
        end
        chk("exit_tick", n, 240);
        chk("exit_slot0_idle", int'(bus.active[0]), 0);

        do_reset();
        bus.player_x = 10'd1000;
        for (int k = 0; k < 30; k++) step(1, 1);
        bus.player_x = 10'(cx);
        bus.player_y = 10'd100;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            step(1, 1);
            n++;
            if (bus.hit) break;
        end
        chk("hit_tick", n, 28);
        chk("hit_idx0", int'(bus.hit_idx), 0);
        bus.hcount = 10'(cx);
        bus.vcount = 10'd54;
        step(0, 1);
        chk("flash_off", int'(bus.data), 0);
        step(1, 1);
        step(0, 1);
        chk("flash_on", int'(bus.data), 6);
        n = 1;
        while (bus.active[0] && n < 40) begin
            step(1, 1);
            n++;
        end
        chk("hit_len", n, 16);

        do_reset();
        bus.player_x = 10'd1000;
        n = 0;
        for (int k = 0; k < 300; k++) begin
            if (bus.active == 4'hF) break;
            step(1, 1);
            n++;
        end
        chk("full_tick", n, 120);
        repeat (60) step(1, 1);
        chk("full_hold", int'(bus.active), 15);
        for (int k = 0; k < 50; k++) begin
            bus.hcount = 10'(m_x[0] + (k % 32));
            bus.vcount = 10'(m_y[0] + (k % 48));
            step(1, 0);
            chk("freeze_pix", int'(bus.data), 4);
        end
        chk("freeze_y", m_y[0], 300);

        do_reset();
        bus.offset_x = 10'($urandom_range(0, 300));
        for (int c = 0; c < 6000; c++) begin
            if (c % 250 == 0) begin
                bus.player_x = 10'(bus.offset_x + $urandom_range(0, 255));
                bus.player_y = 10'($urandom_range(0, 460));
            end
            j = $urandom_range(0, N - 1);
            if (m_st[j] != 0 && $urandom_range(0, 3) != 0) begin
                bus.hcount = 10'(m_x[j] + $urandom_range(0, 33));
                bus.vcount = 10'(m_y[j] + $urandom_range(0, 49));
            end else begin
                bus.hcount = 10'($urandom_range(0, 639));
                bus.vcount = 10'($urandom_range(0, 479));
            end
            if (c == 3000) do_reset();
            step(1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
